// File: rtl/timer_cmd_sequencer.sv
// rtl/timer_cmd_sequencer.sv - arbitrates NREQ requesters onto the shared interval timer slave port
module timer_cmd_sequencer #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_period,
  input  logic [NREQ-1:0]      req_cont,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 timeout_pulse,
  output logic [IDW-1:0]       timeout_id,
  output logic                 busy,
  output logic [2:0]           tmr_address,
  output logic                 tmr_chipselect,
  output logic                 tmr_write_n,
  output logic [15:0]          tmr_writedata,
  input  logic [15:0]          tmr_readdata,
  input  logic                 tmr_irq
);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_SNAP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  // Timer register map
  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PERL   = 3'd2;
  localparam logic [2:0] A_PERH   = 3'd3;
  localparam logic [2:0] A_SNAPL  = 3'd4;
  localparam logic [2:0] A_SNAPH  = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_PL,
    S_W_PH,
    S_W_CTL,
    S_W_STOP,
    S_W_SNAP,
    S_R_SL,
    S_R_SH,
    S_R_CAP,
    S_W_STAT,
    S_RESP,
    S_IRQ_CLR,
    S_IRQ_EVT
  } state_t;

  state_t          state;
  state_t          nxt_state;
  logic [IDW-1:0]  cmd_id;
  logic [IDW-1:0]  nxt_id;
  logic [1:0]      cmd_op;
  logic [1:0]      nxt_op;
  logic [31:0]     cmd_period;
  logic [31:0]     nxt_period;
  logic            cmd_cont;
  logic            nxt_cont;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  nxt_last;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  nxt_owner;
  logic [31:0]     snap;
  logic [31:0]     nxt_snap;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  int              cand;

  logic [NREQ-1:0] o_ready;
  logic            o_rsp_valid;
  logic [IDW-1:0]  o_rsp_id;
  logic [31:0]     o_rsp_data;
  logic            o_timeout;
  logic [IDW-1:0]  o_timeout_id;
  logic            o_cs;
  logic            o_write_n;
  logic [2:0]      o_addr;
  logic [15:0]     o_wdata;

  // Round-robin search starting one past the most recent grant
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_found && req_valid[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  // Next state and next value of every latched register
  always_comb begin
    nxt_state  = state;
    nxt_id     = cmd_id;
    nxt_op     = cmd_op;
    nxt_period = cmd_period;
    nxt_cont   = cmd_cont;
    nxt_last   = last_grant;
    nxt_owner  = owner;
    nxt_snap   = snap;
    case (state)
      S_IDLE: begin
        if (tmr_irq) begin
          nxt_state = S_IRQ_CLR;
        end else if (grant_found) begin
          nxt_id     = grant_idx;
          nxt_op     = req_op[2*int'(grant_idx) +: 2];
          nxt_period = req_period[32*int'(grant_idx) +: 32];
          nxt_cont   = req_cont[grant_idx];
          nxt_last   = grant_idx;
          case (req_op[2*int'(grant_idx) +: 2])
            OP_START: nxt_state = S_W_PL;
            OP_STOP:  nxt_state = S_W_STOP;
            OP_SNAP:  nxt_state = S_W_SNAP;
            default:  nxt_state = S_W_STAT;
          endcase
        end
      end
      S_W_PL:   nxt_state = S_W_PH;
      // Control write must immediately follow the period-high write
      S_W_PH:   nxt_state = S_W_CTL;
      S_W_CTL: begin
        nxt_owner = cmd_id;
        nxt_state = S_RESP;
      end
      S_W_STOP: nxt_state = S_RESP;
      S_W_SNAP: nxt_state = S_R_SL;
      S_R_SL:   nxt_state = S_R_SH;
      // Read data lags the address by one cycle
      S_R_SH: begin
        nxt_snap[15:0] = tmr_readdata;
        nxt_state      = S_R_CAP;
      end
      S_R_CAP: begin
        nxt_snap[31:16] = tmr_readdata;
        nxt_state       = S_RESP;
      end
      S_W_STAT:  nxt_state = S_RESP;
      S_RESP:    nxt_state = S_IDLE;
      S_IRQ_CLR: nxt_state = S_IRQ_EVT;
      S_IRQ_EVT: nxt_state = S_IDLE;
      default:   nxt_state = S_IDLE;
    endcase
  end

  // Moore output decode of the state being entered, registered below
  always_comb begin
    o_ready      = '0;
    o_rsp_valid  = 1'b0;
    o_rsp_id     = '0;
    o_rsp_data   = '0;
    o_timeout    = 1'b0;
    o_timeout_id = '0;
    o_cs         = 1'b0;
    o_write_n    = 1'b1;
    o_addr       = 3'd0;
    o_wdata      = 16'h0000;
    case (nxt_state)
      S_W_PL: begin
        o_ready   = NREQ'(1) << nxt_id;
        o_cs      = 1'b1;
        o_write_n = 1'b0;
        o_addr    = A_PERL;
        o_wdata   = nxt_period[15:0];
      end
      S_W_PH: begin
        o_cs      = 1'b1;
        o_write_n = 1'b0;
        o_addr    = A_PERH;
        o_wdata   = nxt_period[31:16];
      end
      S_W_CTL: begin
        o_cs      = 1'b1;
        o_write_n = 1'b0;
        o_addr    = A_CTRL;
        o_wdata   = nxt_cont ? 16'h0007 : 16'h0005;
      end
      S_W_STOP: begin
        o_ready   = NREQ'(1) << nxt_id;
        o_cs      = 1'b1;
        o_write_n = 1'b0;
        o_addr    = A_CTRL;
        o_wdata   = 16'h0009;
      end
      S_W_SNAP: begin
        o_ready   = NREQ'(1) << nxt_id;
        o_cs      = 1'b1;
        o_write_n = 1'b0;
        o_addr    = A_SNAPL;
      end
      S_R_SL: begin
        o_cs   = 1'b1;
        o_addr = A_SNAPL;
      end
      S_R_SH: begin
        o_cs   = 1'b1;
        o_addr = A_SNAPH;
      end
      S_W_STAT: begin
        o_ready   = NREQ'(1) << nxt_id;
        o_cs      = 1'b1;
        o_write_n = 1'b0;
        o_addr    = A_STATUS;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_id    = nxt_id;
        o_rsp_data  = (nxt_op == OP_SNAP) ? nxt_snap : 32'h0;
      end
      S_IRQ_CLR: begin
        o_cs      = 1'b1;
        o_write_n = 1'b0;
        o_addr    = A_STATUS;
      end
      S_IRQ_EVT: begin
        o_timeout    = 1'b1;
        o_timeout_id = nxt_owner;
      end
      default: ;
    endcase
  end

  // Sequencer state, latched command and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cmd_id         <= '0;
      cmd_op         <= OP_START;
      cmd_period     <= '0;
      cmd_cont       <= 1'b0;
      last_grant     <= IDW'(NREQ-1);
      owner          <= '0;
      snap           <= '0;
      req_ready      <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_data       <= '0;
      timeout_pulse  <= 1'b0;
      timeout_id     <= '0;
      busy           <= 1'b0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 3'd0;
      tmr_writedata  <= 16'h0000;
    end else begin
      state          <= nxt_state;
      cmd_id         <= nxt_id;
      cmd_op         <= nxt_op;
      cmd_period     <= nxt_period;
      cmd_cont       <= nxt_cont;
      last_grant     <= nxt_last;
      owner          <= nxt_owner;
      snap           <= nxt_snap;
      req_ready      <= o_ready;
      rsp_valid      <= o_rsp_valid;
      rsp_id         <= o_rsp_id;
      rsp_data       <= o_rsp_data;
      timeout_pulse  <= o_timeout;
      timeout_id     <= o_timeout_id;
      busy           <= (nxt_state != S_IDLE);
      tmr_chipselect <= o_cs;
      tmr_write_n    <= o_write_n;
      tmr_address    <= o_addr;
      tmr_writedata  <= o_wdata;
    end
  end

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// tb/tb_timer_cmd_sequencer.sv - vector table and corner sequences against a behavioural timer
module tb_timer_cmd_sequencer;

  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_SNAP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                tmr_rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [2*NREQ-1:0]   req_op;
  logic [32*NREQ-1:0]  req_period;
  logic [NREQ-1:0]     req_cont;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_data;
  logic                timeout_pulse;
  logic [IDW-1:0]      timeout_id;
  logic                busy;
  logic [2:0]          tmr_address;
  logic                tmr_chipselect;
  logic                tmr_write_n;
  logic [15:0]         tmr_writedata;
  logic [15:0]         tmr_readdata;
  logic                tmr_irq;

  always #5 clk = ~clk;

  timer_cmd_sequencer #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_op(req_op), .req_period(req_period), .req_cont(req_cont),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .timeout_pulse(timeout_pulse), .timeout_id(timeout_id), .busy(busy),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  // Behavioural interval timer slave
  logic        t_to, t_run, t_ito, t_cont;
  logic [31:0] t_period, t_cnt, t_snap;
  always @(posedge clk) begin
    if (!tmr_rst_n) begin
      t_to <= 1'b0; t_run <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
      t_period <= '0; t_cnt <= '0; t_snap <= '0; tmr_readdata <= '0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to  <= 1'b1;
          t_cnt <= t_period;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito  <= tmr_writedata[0];
            t_cont <= tmr_writedata[1];
            if (tmr_writedata[2]) t_run <= 1'b1;
            else if (tmr_writedata[3]) t_run <= 1'b0;
          end
          3'd2: begin t_period[15:0]  <= tmr_writedata; t_cnt <= {t_period[31:16], tmr_writedata}; t_run <= 1'b0; end
          3'd3: begin t_period[31:16] <= tmr_writedata; t_cnt <= {tmr_writedata, t_period[15:0]};  t_run <= 1'b0; end
          3'd4, 3'd5: t_snap <= t_cnt;
          default: ;
        endcase
      end
      if (tmr_chipselect && tmr_write_n) begin
        case (tmr_address)
          3'd0:    tmr_readdata <= {14'h0, t_run, t_to};
          3'd4:    tmr_readdata <= t_snap[15:0];
          3'd5:    tmr_readdata <= t_snap[31:16];
          default: tmr_readdata <= 16'h0;
        endcase
      end else begin
        tmr_readdata <= 16'h0;
      end
    end
  end
  assign tmr_irq = t_to & t_ito;

  typedef struct { int cyc; int id; logic [31:0] data; } ev_t;
  typedef struct { int cyc; logic [2:0] addr; logic wr; logic [15:0] data; } acc_t;
  // acc encoding: [20] check data, [19] write, [18:16] address, [15:0] data
  typedef struct {
    int id; logic [1:0] op; logic [31:0] period; logic cont;
    int lat; logic snap; int n_acc; logic [2:0][20:0] acc;
  } vec_t;

  ev_t  grant_q[$];
  ev_t  rsp_q[$];
  ev_t  to_q[$];
  acc_t acc_q[$];
  int   cyc, n_chk, n_pass, bus_err, hot_err;
  vec_t vecs[12];

  function automatic logic [20:0] wa(input logic [2:0] a, input logic [15:0] d);
    return {1'b1, 1'b1, a, d};
  endfunction
  function automatic logic [20:0] wx(input logic [2:0] a);
    return {1'b0, 1'b1, a, 16'h0};
  endfunction
  function automatic logic [20:0] ra(input logic [2:0] a);
    return {1'b0, 1'b0, a, 16'h0};
  endfunction

  function automatic vec_t mk(input int id, input logic [1:0] op, input logic [31:0] period,
                              input logic cont, input int lat, input logic snap, input int n,
                              input logic [20:0] a0, input logic [20:0] a1, input logic [20:0] a2);
    vec_t v;
    v.id = id; v.op = op; v.period = period; v.cont = cont;
    v.lat = lat; v.snap = snap; v.n_acc = n;
    v.acc[0] = a0; v.acc[1] = a1; v.acc[2] = a2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  task automatic clear_logs();
    grant_q.delete(); rsp_q.delete(); to_q.delete(); acc_q.delete();
  endtask

  // One clock; outputs sampled on the falling edge, requesters drop valid on ready
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (tmr_chipselect) acc_q.push_back('{cyc, tmr_address, !tmr_write_n, tmr_writedata});
    else if (tmr_address != 3'd0 || !tmr_write_n || tmr_writedata != 16'h0) bus_err++;
    if (req_ready != '0) begin
      if (!$onehot(req_ready)) hot_err++;
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) begin
          grant_q.push_back('{cyc, i, 32'h0});
          req_valid[i] = 1'b0;
        end
    end
    if (rsp_valid) rsp_q.push_back('{cyc, int'(rsp_id), rsp_data});
    if (timeout_pulse) to_q.push_back('{cyc, int'(timeout_id), 32'h0});
  endtask

  task automatic drive(input int id, input logic [1:0] op, input logic [31:0] period, input logic cont);
    req_op[id*2 +: 2]       = op;
    req_period[id*32 +: 32] = period;
    req_cont[id]            = cont;
    req_valid[id]           = 1'b1;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 20) begin tick(); g++; end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int g, c0;
    wait_idle();
    clear_logs();
    c0 = cyc;
    drive(v.id, v.op, v.period, v.cont);
    g = 0;
    while (rsp_q.size() == 0 && g < 12) begin tick(); g++; end
    chk({tag, "/grant_n"}, grant_q.size(), 1);
    if (grant_q.size() > 0) begin
      chk({tag, "/grant_cyc"}, grant_q[0].cyc - c0, 1);
      chk({tag, "/grant_id"}, grant_q[0].id, v.id);
    end
    chk({tag, "/acc_n"}, acc_q.size(), v.n_acc);
    for (int k = 0; k < v.n_acc && k < acc_q.size(); k++) begin
      chk({tag, "/acc_cyc"}, acc_q[k].cyc - c0, k + 1);
      chk({tag, "/acc_addr"}, acc_q[k].addr, v.acc[k][18:16]);
      chk({tag, "/acc_wr"}, acc_q[k].wr, v.acc[k][19]);
      if (v.acc[k][20]) chk({tag, "/acc_data"}, acc_q[k].data, v.acc[k][15:0]);
    end
    chk({tag, "/rsp_n"}, rsp_q.size(), 1);
    if (rsp_q.size() > 0) begin
      chk({tag, "/rsp_cyc"}, rsp_q[0].cyc - c0, v.lat);
      chk({tag, "/rsp_id"}, rsp_q[0].id, v.id);
      chk({tag, "/rsp_data"}, rsp_q[0].data, v.snap ? t_snap : 32'h0);
    end
  endtask

  // START with ito set, then expect one serviced IRQ tagged with the owner
  task automatic irq_case(input vec_t v, input string tag);
    int g, c_irq;
    logic irq_at_pulse;
    run_vec(v, tag);
    clear_logs();
    c_irq = -1;
    irq_at_pulse = 1'b1;
    g = 0;
    while (to_q.size() == 0 && g < 60) begin
      tick();
      if (tmr_irq && c_irq < 0) c_irq = cyc;
      if (timeout_pulse) irq_at_pulse = tmr_irq;
      g++;
    end
    chk({tag, "/irq_seen"}, c_irq >= 0, 1);
    chk({tag, "/to_n"}, to_q.size(), 1);
    if (to_q.size() > 0) begin
      chk({tag, "/to_cyc"}, to_q[0].cyc - c_irq, 2);
      chk({tag, "/to_id"}, to_q[0].id, v.id);
    end
    if (acc_q.size() > 0) begin
      chk({tag, "/clr_cyc"}, acc_q[0].cyc - c_irq, 1);
      chk({tag, "/clr_addr"}, acc_q[0].addr, 3'd0);
      chk({tag, "/clr_wr"}, acc_q[0].wr, 1'b1);
    end else chk({tag, "/clr_n"}, acc_q.size(), 1);
    chk({tag, "/irq_low"}, irq_at_pulse, 1'b0);
    repeat (20) tick();
    chk({tag, "/to_once"}, to_q.size(), 1);
    chk({tag, "/no_ready"}, grant_q.size(), 0);
  endtask

  initial begin
    int g, c0;
    cyc = 0; n_chk = 0; n_pass = 0; bus_err = 0; hot_err = 0;
    req_valid = '0; req_op = '0; req_period = '0; req_cont = '0;
    reset_n = 1'b0; tmr_rst_n = 1'b0;

    vecs[0]  = mk(0, OP_START, 32'h0001_2345, 1'b1, 4, 1'b0, 3, wa(3'd2, 16'h2345), wa(3'd3, 16'h0001), wa(3'd1, 16'h0007));
    vecs[1]  = mk(1, OP_STOP,  32'h0,         1'b0, 2, 1'b0, 1, wa(3'd1, 16'h0009), 21'h0, 21'h0);
    vecs[2]  = mk(1, OP_START, 32'h0000_C000, 1'b1, 4, 1'b0, 3, wa(3'd2, 16'hC000), wa(3'd3, 16'h0000), wa(3'd1, 16'h0007));
    vecs[3]  = mk(0, OP_SNAP,  32'h0,         1'b0, 5, 1'b1, 3, wx(3'd4), ra(3'd4), ra(3'd5));
    vecs[4]  = mk(1, OP_CLEAR, 32'h0,         1'b0, 2, 1'b0, 1, wa(3'd0, 16'h0000), 21'h0, 21'h0);
    vecs[5]  = mk(0, OP_START, 32'h0002_0000, 1'b0, 4, 1'b0, 3, wa(3'd2, 16'h0000), wa(3'd3, 16'h0002), wa(3'd1, 16'h0005));
    vecs[6]  = mk(0, OP_STOP,  32'h0,         1'b0, 2, 1'b0, 1, wa(3'd1, 16'h0009), 21'h0, 21'h0);
    vecs[7]  = mk(0, OP_CLEAR, 32'h0,         1'b0, 2, 1'b0, 1, wa(3'd0, 16'h0000), 21'h0, 21'h0);
    vecs[8]  = mk(0, OP_START, 32'd10,        1'b0, 4, 1'b0, 3, wa(3'd2, 16'd10), wa(3'd3, 16'h0000), wa(3'd1, 16'h0005));
    vecs[9]  = mk(1, OP_START, 32'd5,         1'b0, 4, 1'b0, 3, wa(3'd2, 16'd5), wa(3'd3, 16'h0000), wa(3'd1, 16'h0005));
    vecs[10] = mk(0, OP_START, 32'd2,         1'b0, 4, 1'b0, 3, wa(3'd2, 16'd2), wa(3'd3, 16'h0000), wa(3'd1, 16'h0005));
    vecs[11] = mk(1, OP_START, 32'h0000_8000, 1'b0, 4, 1'b0, 3, wa(3'd2, 16'h8000), wa(3'd3, 16'h0000), wa(3'd1, 16'h0005));

    repeat (3) @(negedge clk);
    chk("rst/cs", tmr_chipselect, 1'b0);
    chk("rst/write_n", tmr_write_n, 1'b1);
    chk("rst/addr", tmr_address, 3'd0);
    chk("rst/wdata", tmr_writedata, 16'h0);
    chk("rst/ready", req_ready, '0);
    chk("rst/rsp_valid", rsp_valid, 1'b0);
    chk("rst/rsp_id", rsp_id, '0);
    chk("rst/rsp_data", rsp_data, 32'h0);
    chk("rst/to_pulse", timeout_pulse, 1'b0);
    chk("rst/to_id", timeout_id, '0);
    chk("rst/busy", busy, 1'b0);
    reset_n = 1'b1; tmr_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous STARTs right after reset: req0 then req1
    wait_idle();
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    clear_logs();
    c0 = cyc;
    drive(0, OP_START, 32'h0000_1000, 1'b0);
    drive(1, OP_START, 32'h0000_2000, 1'b0);
    g = 0;
    while (rsp_q.size() < 2 && g < 20) begin tick(); g++; end
    chk("rr1/grant_n", grant_q.size(), 2);
    chk("rr1/rsp_n", rsp_q.size(), 2);
    if (grant_q.size() >= 2 && rsp_q.size() >= 2 && acc_q.size() >= 4) begin
      chk("rr1/g0_id", grant_q[0].id, 0);
      chk("rr1/g0_cyc", grant_q[0].cyc - c0, 1);
      chk("rr1/g1_id", grant_q[1].id, 1);
      chk("rr1/g1_cyc", grant_q[1].cyc - c0, 6);
      chk("rr1/r1_cyc", rsp_q[1].cyc - c0, 9);
      chk("rr1/r1_id", rsp_q[1].id, 1);
      chk("rr1/a3_data", acc_q[3].data, 16'h2000);
    end

    // req0 granted last, so a STOP pair goes req1 first
    run_vec(vecs[7], "rr_clear");
    wait_idle();
    clear_logs();
    c0 = cyc;
    drive(0, OP_STOP, 32'h0, 1'b0);
    drive(1, OP_STOP, 32'h0, 1'b0);
    g = 0;
    while (rsp_q.size() < 2 && g < 20) begin tick(); g++; end
    chk("rr2/grant_n", grant_q.size(), 2);
    if (grant_q.size() >= 2 && rsp_q.size() >= 2) begin
      chk("rr2/g0_id", grant_q[0].id, 1);
      chk("rr2/g0_cyc", grant_q[0].cyc - c0, 1);
      chk("rr2/g1_id", grant_q[1].id, 0);
      chk("rr2/g1_cyc", grant_q[1].cyc - c0, 4);
      chk("rr2/r1_cyc", rsp_q[1].cyc - c0, 5);
      chk("rr2/r1_id", rsp_q[1].id, 0);
    end

    irq_case(vecs[8], "irq0");
    irq_case(vecs[9], "irq1");

    // IRQ raised during a SNAPSHOT, req1 waiting: IRQ wins the next IDLE
    run_vec(vecs[10], "irqp_start");
    run_vec(vecs[3], "irqp_snap");
    chk("irqp/pending", tmr_irq, 1'b1);
    clear_logs();
    c0 = cyc + 1;
    drive(1, OP_CLEAR, 32'h0, 1'b0);
    g = 0;
    while (rsp_q.size() == 0 && g < 20) begin tick(); g++; end
    chk("irqp/to_n", to_q.size(), 1);
    if (to_q.size() > 0) begin
      chk("irqp/to_cyc", to_q[0].cyc - c0, 2);
      chk("irqp/to_id", to_q[0].id, 0);
    end
    chk("irqp/grant_n", grant_q.size(), 1);
    if (grant_q.size() > 0) begin
      chk("irqp/g_cyc", grant_q[0].cyc - c0, 4);
      chk("irqp/g_id", grant_q[0].id, 1);
    end
    if (acc_q.size() > 0) begin
      chk("irqp/clr_cyc", acc_q[0].cyc - c0, 1);
      chk("irqp/clr_addr", acc_q[0].addr, 3'd0);
    end
    if (rsp_q.size() > 0) chk("irqp/rsp_cyc", rsp_q[0].cyc - c0, 5);

    // Reset during W_PH of a START
    wait_idle();
    clear_logs();
    drive(0, OP_START, 32'h0000_8000, 1'b0);
    tick(); tick();
    chk("rstmid/in_ph", tmr_address, 3'd3);
    reset_n = 1'b0;
    tick();
    chk("rstmid/cs", tmr_chipselect, 1'b0);
    chk("rstmid/write_n", tmr_write_n, 1'b1);
    chk("rstmid/busy", busy, 1'b0);
    chk("rstmid/rsp", rsp_valid, 1'b0);
    reset_n = 1'b1;
    repeat (6) tick();
    chk("rstmid/no_rsp", rsp_q.size(), 0);
    run_vec(vecs[11], "rstmid_start");

    chk("bus_idle_clean", bus_err, 0);
    chk("ready_onehot", hot_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_cmd_sequencer.md
# timer_cmd_sequencer

Command sequencer and arbiter that shares the NIOS system interval timer between NREQ hardware requesters. It accepts start/stop/snapshot/clear commands and turns each one into the correct ordered series of 16-bit register accesses on the timer's slave port. It also services the timer IRQ itself: it clears the status and reports a timeout pulse tagged with the requester that last started the timer. It sits between game-logic clients and the timer slave, alongside the CPU.

## Interface
- NREQ, 2, number of requesters (2..8)
- IDW, 1, requester id width, ceil(log2(NREQ))
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester command valid; held until matching req_ready
- req_op  in  2*NREQ  per-requester op: 0 START, 1 STOP, 2 SNAPSHOT, 3 CLEAR
- req_period  in  32*NREQ  per-requester period for START
- req_cont  in  NREQ  per-requester continuous-mode bit for START
- req_ready  out  NREQ  one-cycle accept pulse, one-hot
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  IDW  requester id of completed command
- rsp_data  out  32  snapshot value for SNAPSHOT, else 0
- timeout_pulse  out  1  one-cycle pulse per serviced timer IRQ
- timeout_id  out  IDW  owner (last START requester) at timeout
- busy  out  1  high in every state except IDLE
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  timer write strobe, active low
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data; registered in the timer, valid the cycle after the address
- tmr_irq  in  1  timer interrupt

## Operation
- Timer map: 0 status (write clears timeout), 1 control {stop,start,cont,ito}, 2/3 period low/high, 4/5 snapshot (write captures, read returns low/high).
- Outputs are Moore outputs decoded from the registered state and latched command. There is no combinational input-to-output path.
- Idle bus: chipselect=0, write_n=1, address=0, writedata=0.
- IDLE:
  - If tmr_irq=1, go to IRQ_CLR. The IRQ has priority over requests.
  - Otherwise, if any req_valid is set, grant round-robin, starting the search from last_grant+1.
  - Latch id, op, period and cont at the grant edge. Update last_grant.
- req_ready[id] pulses in the first state of the granted op.
- START: W_PL (addr 2, period[15:0]) -> W_PH (addr 3, period[31:16]) -> W_CTL (addr 1, 4'b0111 if cont, else 4'b0101) -> RESP. owner<=id at W_CTL.
  - The control write must directly follow the period-high write. The timer's start has priority over its post-period reload stop.
- STOP: W_STOP (addr 1, 4'b1001, keeping ito) -> RESP.
- SNAPSHOT: W_SNAP (write addr 4) -> R_SL (read addr 4) -> R_SH (read addr 5; snap[15:0]<=readdata) -> R_CAP (bus idle; snap[31:16]<=readdata) -> RESP.
- CLEAR: W_STAT (write addr 0, data 0) -> RESP.
- RESP: rsp_valid=1, rsp_id=id, rsp_data=snap for SNAPSHOT, else 0. Next state IDLE.
- IRQ_CLR: write addr 0 -> IRQ_EVT.
- IRQ_EVT: timeout_pulse=1, timeout_id=owner. Next state IDLE.
  - The timer drops irq in IRQ_EVT, so the IRQ is never serviced twice.
- A timeout event coinciding with the clear write is lost; this is the timer's own rule, and the sequencer adds no recovery.
- A requester dropping req_valid before ready is ignored. Its command may still be granted if it was latched.

## Timing
- Cycle 0 is the IDLE cycle with the grant or IRQ decision.
- Cycle 1 is the first bus access, and req_ready is asserted in cycle 1.
- rsp_valid arrives at:
  - START: cycle 4
  - STOP: cycle 2
  - CLEAR: cycle 2
  - SNAPSHOT: cycle 5
- timeout_pulse arrives at cycle 2 after the IRQ is sampled.
- Each bus access lasts exactly one cycle. Consecutive accesses are back-to-back.
- Minimum spacing between grants is the op length plus one IDLE cycle.
- Reset values: all tmr_* outputs idle, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, timeout_pulse=0, timeout_id=0, busy=0. Internal registers reset to last_grant=NREQ-1 and owner=0.
- Reset mid-operation: the next state is IDLE and the bus goes idle on the following cycle. A partially programmed timer is left as-is and no response is issued.

## Test plan
- Req0 START period 0x0001_2345, cont=1. Required response:
  - Writes (2,0x2345), (3,0x0001), (1,0x7) on cycles 1-3.
  - req_ready[0] on cycle 1.
  - rsp_valid with id 0 on cycle 4.
  - The timer then runs continuously.
- Req0 and req1 issue START in the same cycle after reset. Req0 is served first and req1 immediately after. A second pair of STOPs is served req1 then req0.
- START period 10, cont=0, ito=1 -> tmr_irq asserts. Required response: status write on the following cycle, then timeout_pulse with timeout_id=0, then irq low. No second pulse.
- SNAPSHOT with the timer running at 0x0000_C000. Required response:
  - Access sequence is write 4, read 4, read 5.
  - rsp_data equals the timer's captured snapshot on cycle 5.
  - rsp_id is correct.
- IRQ pending while req1 is valid in IDLE. The IRQ is serviced first, then req1 is granted. req_ready is never asserted during IRQ_CLR.
- reset_n low during W_PH of a START. Required response: bus idle next cycle, no rsp_valid, busy=0. A subsequent START completes normally.
